// File: rtl/bubbledrive8_pwrmon.sv
// Power-input conditioning for the startup controller: synchronises and debounces PWRSTAT/MRST,
// then publishes a registered mode code with settle qualification and change pulses.
module bubbledrive8_pwrmon #(
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned SETTLE   = 64
) (
  input  logic       MCLK,
  input  logic       RST,
  input  logic       PWRSTAT,
  input  logic       MRST,
  output logic       PWRSTAT_DB,
  output logic       MRST_DB,
  output logic [1:0] MODE,
  output logic       nMODEVALID,
  output logic       MODECHG,
  output logic [7:0] GLITCHCNT
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE - 1);
  localparam logic [15:0] ST_LAST = 16'(SETTLE - 1);

  typedef enum logic [1:0] {ST_INIT, ST_SETTLE, ST_VALID, ST_CHG} state_t;

  // Channel index 1 = PWRSTAT, 0 = MRST, so db lines up with MODE bit order.
  logic [1:0]  sync1, sync2, db, mode;
  logic [15:0] dcnt [2];
  logic [1:0]  load, glitch;
  logic [7:0]  gcnt, gcnt_nxt;
  logic [8:0]  gsum;
  state_t      state, state_nxt;
  logic [15:0] scnt, scnt_nxt;

  always_comb begin
    load   = '0;
    glitch = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      load[i]   = (sync2[i] != db[i]) && (dcnt[i] == DB_LAST);
      glitch[i] = (sync2[i] == db[i]) && (dcnt[i] != '0);
    end
    gsum     = {1'b0, gcnt} + 9'(glitch[0]) + 9'(glitch[1]);
    gcnt_nxt = gsum[8] ? 8'hFF : gsum[7:0];
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      sync1   <= '1;
      sync2   <= '1;
      db      <= '1;
      mode    <= '1;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
      gcnt    <= '0;
    end else begin
      sync1 <= {PWRSTAT, MRST};
      sync2 <= sync1;
      mode  <= db;
      gcnt  <= gcnt_nxt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (load[i]) begin
          db[i]   <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      state <= ST_INIT;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
    end
  end

  // Settle restarts on the acceptance edge itself; VALID/CHG compare db against
  // the registered MODE so the pulse lines up with MODE's update.
  always_comb begin
    state_nxt  = state;
    scnt_nxt   = scnt;
    nMODEVALID = 1'b1;
    MODECHG    = 1'b0;
    case (state)
      ST_INIT: begin
        scnt_nxt  = '0;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (|load)                 scnt_nxt  = '0;
        else if (scnt == ST_LAST)  state_nxt = ST_VALID;
        else if (scnt != '1)       scnt_nxt  = scnt + 16'd1;
      end
      ST_VALID: begin
        nMODEVALID = 1'b0;
        if (db != mode) state_nxt = ST_CHG;
      end
      ST_CHG: begin
        nMODEVALID = 1'b0;
        MODECHG    = 1'b1;
        state_nxt  = (db != mode) ? ST_CHG : ST_VALID;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign PWRSTAT_DB = db[1];
  assign MRST_DB    = db[0];
  assign MODE       = mode;
  assign GLITCHCNT  = gcnt;

endmodule

// File: tb/tb_bubbledrive8_pwrmon.sv
// Directed bench for bubbledrive8_pwrmon with DEBOUNCE=16, SETTLE=64; timings hand-derived.
module tb_bubbledrive8_pwrmon;

  logic       MCLK = 1'b0;
  logic       RST = 1'b1;
  logic       PWRSTAT = 1'b0;
  logic       MRST = 1'b0;
  logic       PWRSTAT_DB, MRST_DB, nMODEVALID, MODECHG;
  logic [1:0] MODE;
  logic [7:0] GLITCHCNT;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  bubbledrive8_pwrmon #(.DEBOUNCE(16), .SETTLE(64)) dut (
    .MCLK(MCLK), .RST(RST), .PWRSTAT(PWRSTAT), .MRST(MRST),
    .PWRSTAT_DB(PWRSTAT_DB), .MRST_DB(MRST_DB), .MODE(MODE),
    .nMODEVALID(nMODEVALID), .MODECHG(MODECHG), .GLITCHCNT(GLITCHCNT)
  );

  always #5 MCLK = ~MCLK;

  task automatic tick;
    @(posedge MCLK);
    #1;
  endtask

  task automatic tick_mon;
    tick();
    if (MODECHG === 1'b1) pulses++;
  endtask

  task automatic test_reset;
    RST = 1'b1; PWRSTAT = 1'b0; MRST = 1'b0;
    tick(); tick();
    checks++; if (PWRSTAT_DB !== 1'b1) begin errors++; $display("FAIL rst_pdb got %b want 1", PWRSTAT_DB); end
    checks++; if (MRST_DB !== 1'b1) begin errors++; $display("FAIL rst_mdb got %b want 1", MRST_DB); end
    checks++; if (MODE !== 2'b11) begin errors++; $display("FAIL rst_mode got %b want 11", MODE); end
    checks++; if (nMODEVALID !== 1'b1) begin errors++; $display("FAIL rst_nmv got %b want 1", nMODEVALID); end
    checks++; if (MODECHG !== 1'b0) begin errors++; $display("FAIL rst_chg got %b want 0", MODECHG); end
    checks++; if (GLITCHCNT !== 8'd0) begin errors++; $display("FAIL rst_gcnt got %0d want 0", GLITCHCNT); end
    RST = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 90; k++) begin
      tick_mon();
      if (k == 17) begin
        checks++; if (PWRSTAT_DB !== 1'b1) begin errors++; $display("FAIL boot_pdb17 got %b want 1", PWRSTAT_DB); end
      end
      if (k == 18) begin
        checks++; if ({PWRSTAT_DB, MRST_DB} !== 2'b00) begin errors++; $display("FAIL boot_db18 got %b want 00", {PWRSTAT_DB, MRST_DB}); end
        checks++; if (MODE !== 2'b11) begin errors++; $display("FAIL boot_mode18 got %b want 11", MODE); end
      end
      if (k == 19) begin
        checks++; if (MODE !== 2'b00) begin errors++; $display("FAIL boot_mode19 got %b want 00", MODE); end
      end
      if (k == 81) begin
        checks++; if (nMODEVALID !== 1'b1) begin errors++; $display("FAIL boot_nmv81 got %b want 1", nMODEVALID); end
      end
      if (k == 82) begin
        checks++; if (nMODEVALID !== 1'b0) begin errors++; $display("FAIL boot_nmv82 got %b want 0", nMODEVALID); end
        checks++; if (MODE !== 2'b00) begin errors++; $display("FAIL boot_mode82 got %b want 00", MODE); end
      end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL boot_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_raise;
    PWRSTAT = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 22; k++) begin
      tick_mon();
      if (k == 17) begin
        checks++; if (PWRSTAT_DB !== 1'b0) begin errors++; $display("FAIL raise_pdb17 got %b want 0", PWRSTAT_DB); end
      end
      if (k == 18) begin
        checks++; if (PWRSTAT_DB !== 1'b1) begin errors++; $display("FAIL raise_pdb18 got %b want 1", PWRSTAT_DB); end
        checks++; if (MODE !== 2'b00) begin errors++; $display("FAIL raise_mode18 got %b want 00", MODE); end
        checks++; if (MODECHG !== 1'b0) begin errors++; $display("FAIL raise_chg18 got %b want 0", MODECHG); end
      end
      if (k == 19) begin
        checks++; if (MODE !== 2'b10) begin errors++; $display("FAIL raise_mode19 got %b want 10", MODE); end
        checks++; if (MODECHG !== 1'b1) begin errors++; $display("FAIL raise_chg19 got %b want 1", MODECHG); end
        checks++; if (nMODEVALID !== 1'b0) begin errors++; $display("FAIL raise_nmv19 got %b want 0", nMODEVALID); end
      end
      if (k == 20) begin
        checks++; if (MODECHG !== 1'b0) begin errors++; $display("FAIL raise_chg20 got %b want 0", MODECHG); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL raise_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_glitch;
    pulses = 0;
    MRST = 1'b1;
    repeat (10) tick_mon();
    MRST = 1'b0;
    repeat (6) tick_mon();
    checks++; if (GLITCHCNT !== 8'd1) begin errors++; $display("FAIL glitch_one got %0d want 1", GLITCHCNT); end
    checks++; if (MODE !== 2'b10) begin errors++; $display("FAIL glitch_mode got %b want 10", MODE); end
    for (int n = 0; n < 299; n++) begin
      MRST = 1'b1;
      repeat (5) tick_mon();
      MRST = 1'b0;
      repeat (5) tick_mon();
    end
    repeat (3) tick_mon();
    checks++; if (GLITCHCNT !== 8'd255) begin errors++; $display("FAIL glitch_sat got %0d want 255", GLITCHCNT); end
    checks++; if (MRST_DB !== 1'b0) begin errors++; $display("FAIL glitch_mdb got %b want 0", MRST_DB); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_both;
    pulses = 0;
    MRST = 1'b1;
    repeat (22) tick_mon();
    checks++; if (MODE !== 2'b11) begin errors++; $display("FAIL both_setup got %b want 11", MODE); end
    pulses = 0;
    PWRSTAT = 1'b0; MRST = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick_mon();
      if (k == 19) begin
        checks++; if (MODECHG !== 1'b1) begin errors++; $display("FAIL both_chg19 got %b want 1", MODECHG); end
        checks++; if (MODE !== 2'b00) begin errors++; $display("FAIL both_mode19 got %b want 00", MODE); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL both_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_settle_toggle;
    PWRSTAT = 1'b1; MRST = 1'b1; RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      tick();
      checks++; if (nMODEVALID !== (k < 122 ? 1'b1 : 1'b0)) begin errors++; $display("FAIL settle_nmv k=%0d got %b want %b", k, nMODEVALID, (k < 122 ? 1'b1 : 1'b0)); end
      checks++; if (MODECHG !== 1'b0) begin errors++; $display("FAIL settle_chg k=%0d got %b want 0", k, MODECHG); end
      if (k == 57) begin
        checks++; if (MRST_DB !== 1'b1) begin errors++; $display("FAIL settle_mdb57 got %b want 1", MRST_DB); end
      end
      if (k == 58) begin
        checks++; if (MRST_DB !== 1'b0) begin errors++; $display("FAIL settle_mdb58 got %b want 0", MRST_DB); end
      end
      if (k == 122) begin
        checks++; if (MODE !== 2'b10) begin errors++; $display("FAIL settle_mode got %b want 10", MODE); end
      end
      if (k == 40) MRST = 1'b0;
    end
    checks++; if (GLITCHCNT !== 8'd0) begin errors++; $display("FAIL settle_gcnt got %0d want 0", GLITCHCNT); end
  endtask

  task automatic test_double_glitch;
    pulses = 0;
    PWRSTAT = 1'b0; MRST = 1'b1;
    repeat (5) tick_mon();
    PWRSTAT = 1'b1; MRST = 1'b0;
    repeat (6) tick_mon();
    checks++; if (GLITCHCNT !== 8'd2) begin errors++; $display("FAIL dglitch_gcnt got %0d want 2", GLITCHCNT); end
    checks++; if (MODE !== 2'b10) begin errors++; $display("FAIL dglitch_mode got %b want 10", MODE); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL dglitch_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_reset_mid;
    pulses = 0;
    PWRSTAT = 1'b0;
    repeat (10) tick_mon();
    checks++; if (PWRSTAT_DB !== 1'b1) begin errors++; $display("FAIL mid_pdb got %b want 1", PWRSTAT_DB); end
    RST = 1'b1;
    tick_mon();
    checks++; if ({PWRSTAT_DB, MRST_DB, MODE} !== 4'b1111) begin errors++; $display("FAIL mid_rst_db got %b want 1111", {PWRSTAT_DB, MRST_DB, MODE}); end
    checks++; if ({nMODEVALID, MODECHG} !== 2'b10) begin errors++; $display("FAIL mid_rst_ctl got %b want 10", {nMODEVALID, MODECHG}); end
    checks++; if (GLITCHCNT !== 8'd0) begin errors++; $display("FAIL mid_rst_gcnt got %0d want 0", GLITCHCNT); end
    RST = 1'b0; PWRSTAT = 1'b1; MRST = 1'b1;
    repeat (70) tick_mon();
    checks++; if ({nMODEVALID, MODE} !== 3'b011) begin errors++; $display("FAIL mid_valid got %b want 011", {nMODEVALID, MODE}); end
    PWRSTAT = 1'b0;
    for (int k = 1; k <= 19; k++) tick_mon();
    checks++; if (MODECHG !== 1'b1) begin errors++; $display("FAIL chg_setup got %b want 1", MODECHG); end
    pulses = 0;
    RST = 1'b1;
    tick_mon();
    RST = 1'b0;
    checks++; if ({PWRSTAT_DB, MODE, MODECHG, nMODEVALID} !== 5'b11101) begin errors++; $display("FAIL chg_rst got %b want 11101", {PWRSTAT_DB, MODE, MODECHG, nMODEVALID}); end
    repeat (30) tick_mon();
    checks++; if (pulses != 0) begin errors++; $display("FAIL chg_rst_pulses got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_raise();
    test_glitch();
    test_both();
    test_settle_toggle();
    test_double_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
